// File: rtl/mhp_pkg.sv
// mhp_pkg: shared definitions for the MHP TX framer.
//   - state_e     : framer FSM state encoding
//   - hdr_t       : latched header fields
//   - HDR_LEN     : number of header bytes on the wire (7)
//   - OFF_*       : position of each header byte inside the header
//   - SCS_W       : width of the simple checksum
//   - hdr_byte()  : selects header byte N from a latched header
package mhp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_SCS1 = 3'd3,
    ST_SCS2 = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  localparam int HDR_LEN = 7;
  localparam int SCS_W   = 16;

  localparam logic [2:0] OFF_DST_HI  = 3'd0;
  localparam logic [2:0] OFF_DST_LO  = 3'd1;
  localparam logic [2:0] OFF_SRC_HI  = 3'd2;
  localparam logic [2:0] OFF_SRC_LO  = 3'd3;
  localparam logic [2:0] OFF_SIZE_HI = 3'd4;
  localparam logic [2:0] OFF_SIZE_LO = 3'd5;
  localparam logic [2:0] OFF_TYPE    = 3'd6;

  typedef struct packed {
    logic [15:0] dst;
    logic [15:0] src;
    logic [15:0] size;
    logic        dir;
    logic [6:0]  dtype;
  } hdr_t;

  function automatic logic [7:0] hdr_byte(input hdr_t h, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      OFF_DST_HI:  b = h.dst[15:8];
      OFF_DST_LO:  b = h.dst[7:0];
      OFF_SRC_HI:  b = h.src[15:8];
      OFF_SRC_LO:  b = h.src[7:0];
      OFF_SIZE_HI: b = h.size[15:8];
      OFF_SIZE_LO: b = h.size[7:0];
      OFF_TYPE:    b = {h.dir, h.dtype};
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mhp_scs_acc.sv
// mhp_scs_acc: 16-bit wrap-around byte-sum accumulator.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : restart the sum (if i_add is also high the sum restarts at i_din)
//   i_add          : add the zero-extended i_din to the sum
//   i_din [7:0]    : byte to accumulate
//   o_sum [15:0]   : current sum
module mhp_scs_acc
  import mhp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_add,
  input  logic [7:0]       i_din,
  output logic [SCS_W-1:0] o_sum
);

  logic [SCS_W-1:0] sum_q;
  logic [SCS_W-1:0] sum_d;
  logic [SCS_W-1:0] din_ext;

  assign din_ext = {{(SCS_W-8){1'b0}}, i_din};

  // Clear and add together lets the first header byte be summed in the
  // same cycle the frame is accepted.
  always_comb begin
    sum_d = sum_q;
    if (i_clr) begin
      sum_d = i_add ? din_ext : '0;
    end else if (i_add) begin
      sum_d = sum_q + din_ext;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;

endmodule

// File: rtl/mhp_tx_framer.sv
// mhp_tx_framer: builds one MHP frame per accepted start request:
//   DST(2) SRC(2) SIZE(2) {dir,dtype}(1) payload(SIZE) SCS(2), MSB first.
// Ports:
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_start                     : one-cycle frame request (ignored while busy)
//   i_dst/i_src/i_size/i_dir/i_dtype : header fields, sampled with i_start
//   i_pdata/i_pvalid/o_pready   : payload byte stream in
//   o_wdata/o_wvalid/i_wready   : frame byte stream out
//   o_busy/o_done/o_err         : frame in progress / end pulse / reject pulse
//   o_dbg_state                 : current FSM state (mhp_pkg::state_e)
// Handshake: a byte moves on a port in exactly the cycles where its valid
// and ready are both high. o_wvalid/o_wdata are registered and hold while
// i_wready is low; the register reloads whenever it is empty or draining,
// so a ready sink sees one byte per cycle with no bubbles.
module mhp_tx_framer
  import mhp_pkg::*;
#(
  parameter int MAX_SIZE = 1500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_dst,
  input  logic [15:0] i_src,
  input  logic [15:0] i_size,
  input  logic        i_dir,
  input  logic [6:0]  i_dtype,
  input  logic [7:0]  i_pdata,
  input  logic        i_pvalid,
  output logic        o_pready,
  output logic [7:0]  o_wdata,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_dbg_state
);

  state_e      state_q, state_d;
  hdr_t        hdr_q, hdr_d, hdr_in;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wvalid_q, wvalid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic             load_en;
  logic             start_ok;
  logic             start_bad;
  logic             last_hdr;
  logic             last_pay;
  logic             acc_clr;
  logic             acc_add;
  logic [7:0]       acc_din;
  logic [SCS_W-1:0] acc_sum;

  assign hdr_in    = '{dst: i_dst, src: i_src, size: i_size, dir: i_dir, dtype: i_dtype};
  assign load_en   = !wvalid_q || i_wready;
  assign start_ok  = i_start && (i_size <= 16'(MAX_SIZE));
  assign start_bad = i_start && (i_size >  16'(MAX_SIZE));
  assign last_hdr  = (idx_q == 3'(HDR_LEN - 1));
  // A zero-size frame never enters PAY, but the guard keeps size-1 from
  // underflowing into a bogus match.
  assign last_pay  = (hdr_q.size != 16'd0) && (cnt_q == hdr_q.size - 16'd1);

  mhp_scs_acc u_scs_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (acc_clr),
    .i_add   (acc_add),
    .i_din   (acc_din),
    .o_sum   (acc_sum)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_HDR;
      ST_HDR:  if (load_en && last_hdr) state_d = (hdr_q.size != 16'd0) ? ST_PAY : ST_SCS1;
      ST_PAY:  if (load_en && i_pvalid && last_pay) state_d = ST_SCS1;
      ST_SCS1: if (load_en) state_d = ST_SCS2;
      ST_SCS2: if (load_en) state_d = ST_FIN;
      ST_FIN:  if (wvalid_q && i_wready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    hdr_d    = hdr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    acc_clr  = 1'b0;
    acc_add  = 1'b0;
    acc_din  = 8'h00;
    o_pready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          // Header byte 0 goes straight into the output register so it is
          // visible the cycle after the start request; HDR continues at 1.
          hdr_d    = hdr_in;
          idx_d    = 3'd1;
          cnt_d    = 16'd0;
          wdata_d  = i_dst[15:8];
          wvalid_d = 1'b1;
          busy_d   = 1'b1;
          acc_clr  = 1'b1;
          acc_add  = 1'b1;
          acc_din  = i_dst[15:8];
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end
      ST_HDR: begin
        if (load_en) begin
          wdata_d  = hdr_byte(hdr_q, idx_q);
          wvalid_d = 1'b1;
          acc_add  = 1'b1;
          acc_din  = hdr_byte(hdr_q, idx_q);
          idx_d    = idx_q + 3'd1;
        end
      end
      ST_PAY: begin
        o_pready = load_en;
        if (load_en) begin
          if (i_pvalid) begin
            wdata_d  = i_pdata;
            wvalid_d = 1'b1;
            acc_add  = 1'b1;
            acc_din  = i_pdata;
            cnt_d    = cnt_q + 16'd1;
          end else begin
            // Producer starved: let the held byte drain and show no data.
            wvalid_d = 1'b0;
          end
        end
      end
      ST_SCS1: begin
        if (load_en) begin
          wdata_d  = acc_sum[15:8];
          wvalid_d = 1'b1;
        end
      end
      ST_SCS2: begin
        if (load_en) begin
          wdata_d  = acc_sum[7:0];
          wvalid_d = 1'b1;
        end
      end
      ST_FIN: begin
        if (wvalid_q && i_wready) begin
          wvalid_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        wvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hdr_q    <= '0;
      idx_q    <= 3'd0;
      cnt_q    <= 16'd0;
      wdata_q  <= 8'h00;
      wvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hdr_q    <= hdr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_wdata     = wdata_q;
  assign o_wvalid    = wvalid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/mhp_tx_framer.md
MHP_TX_FRAMER -- requirements
Module: mhp_tx_framer

Interface
REQ-001 The block SHALL have parameter MAX_SIZE, default 1500, giving the largest legal payload length in bytes.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1, a one-cycle request to build a frame from the header inputs.
REQ-005 The block SHALL have the header ports, all inputs: i_dst (16, destination address), i_src (16, source address), i_size (16, payload length), i_dir (1, direction bit) and i_dtype (7, data type).
REQ-006 The block SHALL have the payload ports: i_pdata (input, 8, payload byte), i_pvalid (input, 1, payload byte valid) and o_pready (output, 1, payload byte accepted when o_pready and i_pvalid are both high).
REQ-007 The block SHALL have the eth TX ports: o_wdata (output, 8, frame byte), o_wvalid (output, 1, byte valid) and i_wready (input, 1, sink ready).
REQ-008 The block SHALL have the status ports, all outputs of width 1: o_busy (frame in progress), o_done (one-cycle pulse at frame end) and o_err (one-cycle pulse on a rejected start).

Function
REQ-009 The block SHALL emit each frame on the TX port in the order DST[15:8], DST[7:0], SRC[15:8], SRC[7:0], SIZE[15:8], SIZE[7:0], {dir,dtype}, then size payload bytes, then SCS[15:8], SCS[7:0].
REQ-010 SCS SHALL be the 16-bit wrap-around sum of every header and payload byte, with each byte zero-extended; the two SCS bytes are not included in the sum.
REQ-011 A TX byte SHALL transfer only in a cycle where o_wvalid and i_wready are both high; while o_wvalid is high and i_wready is low, o_wdata SHALL hold stable.
REQ-012 The output register SHALL load the next byte in any cycle where o_wvalid is low or i_wready is high, giving full throughput of one byte per cycle with no bubbles when the sink is always ready.
REQ-013 The state machine SHALL have states IDLE, HDR, PAY, SCS1, SCS2 and FIN, with a 3-bit header index used in HDR.
REQ-014 IDLE transitions: on i_start with i_size <= MAX_SIZE, the block SHALL latch all header inputs, clear the sum, set o_busy and go to HDR; the first header byte SHALL appear on o_wvalid in the following cycle.
REQ-015 IDLE transitions: on i_start with i_size > MAX_SIZE, the block SHALL pulse o_err for one cycle and stay in IDLE with no TX activity.
REQ-016 HDR transitions: after loading header byte 6, the block SHALL go to PAY if the latched size is non-zero, otherwise to SCS1.
REQ-017 In PAY, o_pready SHALL equal (o_wvalid low or i_wready high); every accepted payload byte SHALL be loaded and added to the sum, and the block SHALL go to SCS1 after byte size-1.
REQ-018 o_pready SHALL be low in every state other than PAY.
REQ-019 SCS1 and SCS2 SHALL each load one checksum byte; SCS2 SHALL go to FIN.
REQ-020 In FIN, once the final byte has been accepted, the block SHALL pulse o_done for one cycle, clear o_busy and return to IDLE.
REQ-021 i_start SHALL be ignored while o_busy is high.
REQ-022 The payload counter SHALL be 16 bits and compare against size-1 only when size is non-zero.
REQ-023 If the producer starves (i_pvalid low), the block SHALL wait in PAY indefinitely, with o_wvalid dropping once the held byte has been accepted.

Reset
REQ-024 Asserting i_rst_n low at any time SHALL immediately force state IDLE and drive o_wvalid, o_wdata, o_pready, o_busy, o_done and o_err to 0, with the sum and counters also cleared.
REQ-025 A frame interrupted by reset SHALL be abandoned with no completion; the block SHALL accept i_start from the first clock edge after release.

Structure
REQ-026 A shared package mhp_pkg SHALL hold the state encoding, the header length constant (7), the header byte offsets and the SCS width.
REQ-027 Checksum accumulation SHALL be placed in one sub-module, mhp_scs_acc, with clear, add-enable and an 8-bit input, producing a 16-bit sum.

Verification
REQ-028 Scenario: dst=FFFF, src=0000, size=0, dir=1, dtype=03, with i_wready held high -> TX bytes FF FF 00 00 00 00 83 02 81, followed by one o_done pulse.
REQ-029 Scenario: dst=1234, src=0001, size=2, dtype=05, payload 10 20 -> TX bytes 12 34 00 01 00 02 05 10 20 00 7E, delivered in 11 consecutive cycles.
REQ-030 Scenario: the same frame as REQ-029 with i_wready toggled randomly and i_pvalid gaps -> an identical byte stream, o_wdata stable during every stall, and no payload bytes lost or duplicated.
REQ-031 Scenario: dst=FFFF, src=FFFF, size=300, dir=1, dtype=7F, all payload bytes FF -> SCS 2F FC, exercising 16-bit wrap-around.
REQ-032 Scenario: i_start with size=2000 -> o_err high for exactly one cycle, o_wvalid stays low and o_busy stays low.
REQ-033 Scenario: i_rst_n pulsed low during payload byte 5 of a size-10 frame -> all outputs 0 asynchronously, then a new start after release produces a complete, correct frame.
